adc_capture_buffer: RTL
=======================

# adc_capture_buffer

Armed, triggered capture buffer for one RFSoC ADC stream (MAC or NL path). It records a programmed number of 128-bit ADC beats (8 × 16-bit samples each) into an internal FIFO. It presents them as a first-word-fall-through valid/ready stream to the GPIO readback block, which drains each word as four 32-bit reads. One instance sits upstream of each of the `mac_adc_*` and `nl_adc_*` readback ports.

## Interface
Parameters:
- `DEPTH`, 256: FIFO depth in 128-bit words; power of two, ≥ 2.
- `LEN_W`, 16: width of the capture-length register.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `adc_tdata`  in  128  ADC beat; sample 0 in bits [15:0].
- `adc_tvalid`  in  1  beat present; no backpressure toward the ADC.
- `arm`  in  1  single-cycle pulse: flush the FIFO, clear status, wait for trigger.
- `trigger`  in  1  single-cycle pulse: start capture.
- `cap_len`  in  LEN_W  beats to capture; sampled on `trigger`.
- `out_data`  out  128  head-of-FIFO word.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer pops the head word when high with `out_valid`.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky; a beat was dropped because the FIFO was full.
- `fill_count`  out  $clog2(DEPTH)+1  words currently stored.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- **IDLE / DONE:**
  - `arm` → ARMED. On the same edge: read and write pointers zeroed, `fill_count`=0, `overflow`=0.
  - `trigger` is ignored. `adc_tvalid` is ignored.
- **ARMED:**
  - `trigger` → CAPTURE. On the same edge: `len_reg`=`cap_len`, `beat_cnt`=0.
  - If `cap_len`==0 → DONE directly.
  - The beat present in the trigger cycle is not captured.
  - `arm` re-flushes and stays in ARMED.
- **CAPTURE:**
  - Each cycle with `adc_tvalid`=1, `beat_cnt` increments.
  - If `fill_count`<DEPTH at the start of the cycle, the beat is written. Otherwise it is dropped and `overflow` is set.
  - A dropped beat still counts toward `len_reg`, so the capture stays time-aligned.
  - When the incremented `beat_cnt` equals `len_reg` → DONE.
  - `arm` in CAPTURE aborts: flush, → ARMED. `arm` has priority over beat handling in that cycle.
- **`arm` and `trigger` in the same cycle:** `arm` wins and `trigger` is ignored.
- **Read side (independent of state, except flush):**
  - `out_valid` = (`fill_count`≠0).
  - `out_data` = mem[rd_ptr] when valid, otherwise 0.
  - A pop on `out_valid`&&`out_ready` advances rd_ptr.
  - A flush in the same cycle as a pop overrides the pop.
- **Full condition:** full is judged before a same-cycle pop. With `fill_count`==DEPTH, a write is dropped even if a pop occurs in the same cycle.
- **Simultaneous write and pop** when not full: `fill_count` unchanged.
- **Pointers:** $clog2(DEPTH) bits, wrap modulo DEPTH. `fill_count` never exceeds DEPTH and never underflows.
- **`beat_cnt`:** LEN_W bits. `cap_len`=2^LEN_W−1 is the maximum.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `overflow`=0, `fill_count`=0. State IDLE, pointers 0.
- Reset mid-capture discards all stored words.
- Latency from a beat accepted at edge k: `out_valid` and `fill_count` reflect it after edge k (visible in cycle k+1).
- Pop latency: the next head word appears after the popping edge. Back-to-back pops at one word per cycle are supported.
- `busy`/`done` change on the same edge as the state transition.
- The last beat sets `done` after its write edge.
- `out_data`/`out_valid` are combinational from registers. No combinational path from `out_ready` to `out_valid`.

## Test plan
- Reset, `arm`, `trigger` with `cap_len`=4, 4 valid beats 0x…01–0x…04, `out_ready`=0 → `fill_count`=4, `done`=1, `overflow`=0. Then `out_ready`=1 → words 1,2,3,4 appear on consecutive cycles, then `out_valid`=0.
- DEPTH=256, `cap_len`=300, continuous beats, no reads → `fill_count`=256, `overflow`=1, `done` after exactly 300 valid beats. Beats 257–300 are absent from the readout.
- `cap_len`=8 with `adc_tvalid` toggling every other cycle → `done` after the 8th valid beat (≈16 cycles). The stored sequence is exactly the valid beats.
- `arm` issued mid-CAPTURE after 3 beats → `fill_count`=0, state ARMED, `overflow` cleared. A following `trigger` with `cap_len`=2 captures only the new 2 beats.
- `cap_len`=0 → `done`=1 the cycle after `trigger`, `fill_count`=0. `arm`+`trigger` in the same cycle from IDLE → ARMED, not CAPTURE.
- FIFO full with a simultaneous pop and incoming beat → beat dropped, `overflow`=1, `fill_count`=255. Assert `rst` low mid-capture → all outputs return to reset values immediately.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: armed, triggered ADC beat capture into a first-word-fall-through FIFO.
// Dropped beats on a full FIFO still count toward the capture length to keep the record time-aligned.
module adc_capture_buffer #(
    parameter int DEPTH = 256,
    parameter int LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [127:0]             adc_tdata,
    input  logic                     adc_tvalid,
    input  logic                     arm,
    input  logic                     trigger,
    input  logic [LEN_W-1:0]         cap_len,
    output logic [127:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [127:0]      r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [AW:0]       r_fill;
    logic              r_overflow;
    logic [LEN_W-1:0]  r_len, r_beat_cnt;
    logic              w_full, w_beat, w_wr, w_pop, w_start;
    logic [LEN_W-1:0]  w_beat_nxt;

    // arm outranks every other event in the cycle, including a pop
    assign w_full     = r_fill == (AW+1)'(DEPTH);
    assign w_beat     = r_state == CAPTURE && adc_tvalid && !arm;
    assign w_wr       = w_beat && !w_full;
    assign w_pop      = out_valid && out_ready && !arm;
    assign w_start    = r_state == ARMED && trigger && !arm;
    assign w_beat_nxt = r_beat_cnt + LEN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        if (arm)
            w_state_nxt = ARMED;
        else if (w_start)
            w_state_nxt = cap_len == '0 ? DONE : CAPTURE;
        else if (w_beat && w_beat_nxt == r_len)
            w_state_nxt = DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            if (arm) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_fill     <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
                r_fill <= r_fill + (AW+1)'(w_wr) - (AW+1)'(w_pop);
                if (w_beat && w_full) r_overflow <= 1'b1;
            end
            if (w_start) begin
                r_len      <= cap_len;
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= w_beat_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= adc_tdata;
    end

    assign out_valid  = r_fill != '0;
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fill_count = r_fill;
    assign overflow   = r_overflow;
    assign busy       = r_state == ARMED || r_state == CAPTURE;
    assign done       = r_state == DONE;
endmodule
